// File: rtl/gray_add_arbiter.sv
// Round-robin arbiter in front of one shared 4-bit Gray-code adder.
// One transaction in flight: grant, latch operands, register Gray sum/carry, hold until accepted.
module gray_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [3:0]           resp_sum,
    output logic                 resp_cout,
    output logic                 busy,
    output logic [CNT_W-1:0]     txn_count
);

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {IDLE, LATCH, COMPUTE, RESP} state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx, hi_idx, lo_idx;
    logic              grant_any, hi_hit, lo_hit;
    logic [N_REQ-1:0]  grant_oh;
    logic [DATA_W-1:0] sel_a, sel_b;

    logic [DATA_W-1:0] a_p0, b_p0;
    logic [ID_W-1:0]   id_p0;
    logic [DATA_W:0]   sum_bin_p1, sum_gray_p1;

    function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        b[DATA_W-1] = g[DATA_W-1];
        for (int i = DATA_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [DATA_W:0] bin2gray(input logic [DATA_W:0] b);
        return b ^ (b >> 1);
    endfunction

    // Two passes: lowest requester at/above rr_ptr, else lowest below it (wrap).
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                hi_hit = 1'b1;
                hi_idx = ID_W'(i);
            end
            if (req_valid[i] && (ID_W'(i) < rr_ptr)) begin
                lo_hit = 1'b1;
                lo_idx = ID_W'(i);
            end
        end
        grant_any = hi_hit | lo_hit;
        grant_idx = hi_hit ? hi_idx : lo_idx;
        grant_oh  = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[DATA_W*i +: DATA_W];
                sel_b = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (!rst) req_ready = grant_oh;
                if (grant_any) state_nxt = LATCH;
            end
            LATCH:   state_nxt = COMPUTE;
            COMPUTE: state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // Stage p0: operands captured on grant
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_any) begin
            a_p0  <= sel_a;
            b_p0  <= sel_b;
            id_p0 <= grant_idx;
        end
    end

    // Stage p1: shared adder, binary domain then back to 5-bit Gray
    assign sum_bin_p1  = {1'b0, gray2bin(a_p0)} + {1'b0, gray2bin(b_p0)};
    assign sum_gray_p1 = bin2gray(sum_bin_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            resp_id   <= '0;
            resp_sum  <= '0;
            resp_cout <= 1'b0;
            txn_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_any) begin
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == COMPUTE) begin
                resp_sum  <= sum_gray_p1[DATA_W-1:0];
                resp_cout <= sum_gray_p1[DATA_W];
                resp_id   <= id_p0;
            end
            if (state == RESP && resp_ready) begin
                txn_count <= txn_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_add_arbiter.sv
// Directed and randomised checks of gray_add_arbiter with N_REQ=4.
module tb_gray_add_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [3:0]  resp_sum;
    logic        resp_cout;
    logic        busy;
    logic [7:0]  txn_count;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    gray_add_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout),
        .busy(busy), .txn_count(txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference: Gray->binary by prefix XOR, add, binary->Gray.
    function automatic logic [4:0] ref_gray_add(input logic [3:0] ga, input logic [3:0] gb);
        logic [3:0] ba, bb;
        logic [4:0] s;
        for (int i = 0; i < 4; i++) begin
            ba[i] = ^(ga >> i);
            bb[i] = ^(gb >> i);
        end
        s = {1'b0, ba} + {1'b0, bb};
        return s ^ (s >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        nchecks++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        nchecks++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
        nchecks++; if (txn_count !== 8'd0) begin nerr++; $display("FAIL reset_txn got=%0d exp=0", txn_count); end
        nchecks++; if ({resp_id, resp_sum, resp_cout} !== 7'd0) begin nerr++; $display("FAIL reset_resp got=%0h exp=0", {resp_id, resp_sum, resp_cout}); end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        req_valid = 4'b0001;
        req_a[3:0] = 4'b0010;
        req_b[3:0] = 4'b0111;
        resp_ready = 1'b1;
        #1;
        nchecks++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL basic_grant got=%b exp=0001", req_ready); end
        tick();
        nchecks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin nerr++; $display("FAIL basic_latch busy=%b rdy=%b exp 1/0000", busy, req_ready); end
        req_valid = '0;
        req_a[3:0] = 4'b1111;
        req_b[3:0] = 4'b1111;
        tick();
        nchecks++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got=%b exp=0", resp_valid); end
        tick();
        nchecks++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid got=%b exp=1", resp_valid); end
        nchecks++; if ({resp_id, resp_sum, resp_cout} !== {2'd0, 4'b1100, 1'b0}) begin nerr++; $display("FAIL basic_result id=%0d sum=%b cout=%b exp 0/1100/0", resp_id, resp_sum, resp_cout); end
        tick();
        nchecks++; if (resp_valid !== 1'b0 || txn_count !== 8'd1) begin nerr++; $display("FAIL basic_done valid=%b txn=%0d exp 0/1", resp_valid, txn_count); end
    endtask

    task automatic test_carry();
        req_valid = 4'b0100;
        req_a[11:8] = 4'b1000;
        req_b[11:8] = 4'b0001;
        resp_ready = 1'b1;
        #1;
        nchecks++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL carry_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        nchecks++; if (resp_valid !== 1'b1 || {resp_id, resp_sum, resp_cout} !== {2'd2, 4'b1000, 1'b1}) begin nerr++; $display("FAIL carry_result v=%b id=%0d sum=%b cout=%b exp 1/2/1000/1", resp_valid, resp_id, resp_sum, resp_cout); end
        tick();
        nchecks++; if (txn_count !== 8'd2) begin nerr++; $display("FAIL carry_txn got=%0d exp=2", txn_count); end
    endtask

    task automatic test_round_robin();
        int order[5];
        int when[5];
        int ng;
        int gi;
        do_reset();
        req_valid = 4'b1111;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        ng = 0;
        #1;
        for (int c = 0; c < 30 && ng < 5; c++) begin
            if (req_ready !== 4'b0000) begin
                gi = -1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
                order[ng] = gi;
                when[ng] = cyc;
                ng++;
            end
            tick();
        end
        req_valid = '0;
        nchecks++; if (ng !== 5) begin nerr++; $display("FAIL rr_count got=%0d exp=5", ng); end
        for (int k = 0; k < ng; k++) begin
            nchecks++; if (order[k] !== (k % 4)) begin nerr++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, order[k], k % 4); end
            if (k > 0) begin
                nchecks++; if (when[k] - when[k-1] !== 4) begin nerr++; $display("FAIL rr_interval[%0d] got=%0d exp=4", k, when[k] - when[k-1]); end
            end
        end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0011;
        req_a[3:0] = 4'b0001; req_b[3:0] = 4'b0001;
        req_a[7:4] = 4'b0110; req_b[7:4] = 4'b0101;
        resp_ready = 1'b0;
        tick();
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            nchecks++; if (resp_valid !== 1'b1 || {resp_id, resp_sum, resp_cout} !== {2'd0, 4'b0011, 1'b0}) begin nerr++; $display("FAIL bp_hold[%0d] v=%b id=%0d sum=%b cout=%b exp 1/0/0011/0", c, resp_valid, resp_id, resp_sum, resp_cout); end
            nchecks++; if (req_ready !== 4'b0000 || txn_count !== 8'd0) begin nerr++; $display("FAIL bp_block[%0d] rdy=%b txn=%0d exp 0000/0", c, req_ready, txn_count); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        nchecks++; if (resp_valid !== 1'b0 || txn_count !== 8'd1) begin nerr++; $display("FAIL bp_release v=%b txn=%0d exp 0/1", resp_valid, txn_count); end
        nchecks++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        nchecks++; if (busy !== 1'b1) begin nerr++; $display("FAIL bp_next_busy got=%b exp=1", busy); end
        tick();
        tick();
        nchecks++; if ({resp_valid, resp_id, resp_sum, resp_cout} !== {1'b1, 2'd1, 4'b1111, 1'b0}) begin nerr++; $display("FAIL bp_second v=%b id=%0d sum=%b cout=%b exp 1/1/1111/0", resp_valid, resp_id, resp_sum, resp_cout); end
        tick();
        nchecks++; if (txn_count !== 8'd2) begin nerr++; $display("FAIL bp_txn got=%0d exp=2", txn_count); end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        req_valid = 4'b0001;
        req_a = '0;
        req_b = '0;
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        req_valid = 4'b0111;
        #1;
        nchecks++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
        tick();
        nchecks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || txn_count !== 8'd0) begin nerr++; $display("FAIL mid_rst_state v=%b busy=%b txn=%0d exp 0/0/0", resp_valid, busy, txn_count); end
        rst = 1'b0;
        #1;
        nchecks++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL mid_rst_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid) seen++;
            tick();
        end
        nchecks++; if (seen !== 0) begin nerr++; $display("FAIL mid_rst_noresp got=%0d exp=0", seen); end
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic [4:0] exp;
        int idx;
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            idx = i % 4;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            exp = ref_gray_add(a, b);
            req_valid = 4'(1 << idx);
            req_a[4*idx +: 4] = a;
            req_b[4*idx +: 4] = b;
            #1;
            nchecks++; if (req_ready !== 4'(1 << idx)) begin nerr++; $display("FAIL rand_grant[%0d] got=%b", i, req_ready); end
            tick();
            req_valid = '0;
            tick();
            tick();
            nchecks++; if (resp_valid !== 1'b1 || resp_id !== 2'(idx)) begin nerr++; $display("FAIL rand_valid[%0d] v=%b id=%0d exp 1/%0d", i, resp_valid, resp_id, idx); end
            nchecks++; if ({resp_cout, resp_sum} !== exp) begin nerr++; $display("FAIL rand_sum[%0d] a=%b b=%b got=%b exp=%b", i, a, b, {resp_cout, resp_sum}, exp); end
            tick();
            nchecks++; if (txn_count !== 8'(i + 1)) begin nerr++; $display("FAIL rand_txn[%0d] got=%0d exp=%0d", i, txn_count, 8'(i + 1)); end
        end
        nchecks++; if (txn_count !== 8'd0) begin nerr++; $display("FAIL txn_wrap got=%0d exp=0", txn_count); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/gray_add_arbiter.md
Name: gray_add_arbiter

Overview:
- Shares one combinational 4-bit Gray-code adder among N_REQ requesters. Each requester presents a pair of Gray operands with a valid/ready handshake.
- A round-robin arbiter grants one request at a time. A small FSM latches the operands, registers the adder's Gray sum and Gray carry, and holds the result on a single response channel until the consumer accepts it.
- The block sits between operand producers and the shared Gray adder datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8). Operand width is fixed at 4 bits Gray by the adder datapath.
- ID_W, 2, width of resp_id; must satisfy 2**ID_W >= N_REQ.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept, at most one bit set.
- req_a  input  4*N_REQ  Gray operand A; slice i belongs to requester i.
- req_b  input  4*N_REQ  Gray operand B; slice i belongs to requester i.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_sum  output  4  Gray sum (low 4 bits of the 5-bit Gray result).
- resp_cout  output  1  Gray carry (MSB of the 5-bit Gray result).
- busy  output  1  high whenever state != IDLE.
- txn_count  output  CNT_W  count of completed responses; wraps modulo 2**CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, busy=0, txn_count=0.
  - req_ready is forced to 0 while rst=1.
  - A transaction in flight is discarded without any response.
- FSM states are IDLE, LATCH, COMPUTE and RESP.
- IDLE:
  - grant = first set bit of req_valid, searching from rr_ptr upward and wrapping.
  - req_ready = one-hot grant. This is combinational from req_valid and rr_ptr; there is no combinational path from req_a/req_b.
  - If any req_valid is set at the edge, the block latches the granted index, req_a slice and req_b slice, then goes to LATCH.
  - rr_ptr updates to (granted index + 1) mod N_REQ.
  - If no req_valid is set, it stays in IDLE and rr_ptr is unchanged.
- LATCH:
  - Latched operands drive the adder. Binary A + binary B gives a 5-bit binary result, which is converted to 5-bit Gray.
  - Go to COMPUTE. req_ready=0.
- COMPUTE:
  - Register the adder output: resp_sum = Gray[3:0], resp_cout = Gray[4], resp_id = latched index.
  - Go to RESP.
- RESP:
  - resp_valid=1. resp_id, resp_sum and resp_cout are stable until the handshake completes.
  - When resp_valid && resp_ready at an edge: txn_count increments, resp_valid drops, state goes to IDLE.
  - A new grant is possible at the next edge; there is no bypass from RESP straight to a new grant.
- Latency: acceptance at edge T gives resp_valid high after edge T+2. Minimum issue interval is 4 cycles per transaction when resp_ready is held high.
- Only one transaction is in flight. req_ready is 0 in LATCH, COMPUTE and RESP regardless of req_valid.
- Requester rules:
  - A requester may drop req_valid before it is granted; no state changes.
  - Operand changes after acceptance have no effect on the result.
- Simultaneous requests: the lowest index at or above rr_ptr (with wrap) wins. Under continuous load every requester is served within N_REQ grants.
- Arithmetic: unsigned. The Gray carry equals the binary carry (both are the MSB of the result). All 256 operand pairs are legal.
- Counter: txn_count wraps from 2**CNT_W-1 to 0 with no flag.
- Reset mid-operation (any state): the reset values above apply at that edge and no response is issued for the dropped transaction.

Test Plan:
- Reset, then req_valid[0]=1, a0=0010 (bin 3), b0=0111 (bin 5), resp_ready=1.
  - Required: req_ready=0001 at T; resp_valid after T+2 with resp_id=0, resp_sum=1100, resp_cout=0; txn_count=1.
- Requester 2 sends a=1000 (15), b=0001 (1).
  - Required: resp_sum=1000, resp_cout=1 (Gray 11000), resp_id=2.
- All four req_valid held high, resp_ready=1, from reset.
  - Required: grant order 0,1,2,3,0; consecutive accepts are exactly 4 cycles apart.
- Hold resp_ready=0 for 5 cycles in RESP, with other req_valid high.
  - Required: resp_* stable, req_ready=0, txn_count unchanged; when resp_ready=1, exactly one completion and the next grant one cycle after.
- Assert rst during COMPUTE.
  - Required: next cycle resp_valid=0, busy=0, rr_ptr=0, txn_count=0; no response for the dropped request.
- Run 256 completions with random Gray operands against a reference model.
  - Required: every sum/cout matches and txn_count wraps to 0.
